// File: rtl/apb_clint_if.sv
// APB bus bundle for the CLINT responder.
//   psel/penable/paddr/pwrite/pwdata/pwstrb : requester -> responder
//   pready/prdata/pslverr                   : responder -> requester
// ADDR_W sets the width of the decoded address slice.
interface apb_clint_if #(
  parameter int ADDR_W = 16
) ();
  logic              psel;
  logic              penable;
  logic              pready;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pwstrb;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pwstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pwstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_clint.sv
// Single-hart RISC-V core-local interruptor behind an APB responder.
// Holds msip, the 64-bit mtime counter (advanced every TICK_DIV clocks) and
// the 64-bit mtimecmp comparator; drives msip/mtip to the core.
// Every transfer takes exactly one wait state (setup, WAIT, RESP).
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         apb_clint_if.slave (psel/penable/paddr/pwrite/pwdata/pwstrb in,
//               pready/prdata/pslverr out; prdata and pslverr registered)
//   msip        machine software interrupt pending
//   mtip        machine timer interrupt pending (registered)
//
// Map: 0x0000 msip, 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi.
//
// Build option: CLINT_MTIME_WRITE_EN makes mtime writable; without it mtime
// writes complete with pslverr=1 and leave the counter untouched.
module apb_clint #(
  parameter int ADDR_W   = 16,
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  apb_clint_if.slave  bus,
  output logic        msip,
  output logic        mtip
);

  localparam logic [15:0] TICK_M1 = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [2:0] {
    R_NONE, R_MSIP, R_CMP_LO, R_CMP_HI, R_TIME_LO, R_TIME_HI
  } reg_e;

  state_e      state, state_d;
  reg_e        dec, reg_q;
  logic        err_d;
  logic [31:0] rdata_d;
  logic [31:0] prdata_q;
  logic        pslverr_q;
  logic [15:0] presc;
  logic        tick;
  logic [63:0] mtime, mtime_inc, mtimecmp;
  logic        commit;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] wd,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- address decode (used in the WAIT cycle) ----------------
  always_comb begin
    dec = R_NONE;
    if (bus.paddr[1:0] == 2'b00) begin
      case (bus.paddr)
        ADDR_W'(16'h0000): dec = R_MSIP;
        ADDR_W'(16'h4000): dec = R_CMP_LO;
        ADDR_W'(16'h4004): dec = R_CMP_HI;
        ADDR_W'(16'hBFF8): dec = R_TIME_LO;
        ADDR_W'(16'hBFFC): dec = R_TIME_HI;
        default:           dec = R_NONE;
      endcase
    end
  end

  always_comb begin
    err_d = (dec == R_NONE);
`ifndef CLINT_MTIME_WRITE_EN
    if (bus.pwrite && (dec == R_TIME_LO || dec == R_TIME_HI)) err_d = 1'b1;
`endif
  end

  // Reads of mtime see the value after the edge ending WAIT, so a tick in the
  // WAIT cycle is included.
  assign tick      = (presc == TICK_M1);
  assign mtime_inc = tick ? mtime + 64'd1 : mtime;

  always_comb begin
    rdata_d = 32'h0;
    case (dec)
      R_MSIP:    rdata_d = {31'h0, msip};
      R_CMP_LO:  rdata_d = mtimecmp[31:0];
      R_CMP_HI:  rdata_d = mtimecmp[63:32];
      R_TIME_LO: rdata_d = mtime_inc[31:0];
      R_TIME_HI: rdata_d = mtime_inc[63:32];
      default:   rdata_d = 32'h0;
    endcase
  end

  // ---------------- responder FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.psel && !bus.penable) state_d = WAIT;
      WAIT:    state_d = bus.psel ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode result is captured in WAIT so RESP only needs the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata_q  <= 32'h0;
      pslverr_q <= 1'b0;
      reg_q     <= R_NONE;
    end else if (state == WAIT && bus.psel) begin
      prdata_q  <= err_d ? 32'h0 : rdata_d;
      pslverr_q <= err_d;
      reg_q     <= err_d ? R_NONE : dec;
    end
  end

  assign bus.pready  = (state == RESP) && bus.psel;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;

  assign commit = (state == RESP) && bus.psel && bus.penable && bus.pwrite && !pslverr_q;

  // ---------------- architectural registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip     <= 1'b0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (commit) begin
      if (reg_q == R_MSIP && bus.pwstrb[0]) msip <= bus.pwdata[0];
      if (reg_q == R_CMP_LO) mtimecmp[31:0]  <= merge(mtimecmp[31:0],  bus.pwdata, bus.pwstrb);
      if (reg_q == R_CMP_HI) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.pwdata, bus.pwstrb);
    end
  end

  // Prescaler free-runs; a software write to mtime never resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= 16'h0;
    else if (tick) presc <= 16'h0;
    else           presc <= presc + 16'h1;
  end

  // A software write wins over a coincident tick: the whole counter keeps
  // its pre-increment value apart from the written bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= 64'h0;
`ifdef CLINT_MTIME_WRITE_EN
    end else if (commit && reg_q == R_TIME_LO) begin
      mtime[31:0]  <= merge(mtime[31:0], bus.pwdata, bus.pwstrb);
    end else if (commit && reg_q == R_TIME_HI) begin
      mtime[63:32] <= merge(mtime[63:32], bus.pwdata, bus.pwstrb);
`endif
    end else begin
      mtime <= mtime_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mtip <= 1'b0;
    else        mtip <= (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_apb_clint.sv
// Directed self-checking bench for apb_clint (TICK_DIV=4).
// A free-running edge counter (cyc, cleared by reset) gives the reference
// mtime: cyc/4 until software writes mtime.
module tb_apb_clint;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic msip, mtip;
  int checks = 0;
  int failures = 0;
  int unsigned cyc;

  apb_clint_if #(.ADDR_W(16)) bus ();

  apb_clint #(.ADDR_W(16), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .msip(msip), .mtip(mtip)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  // One APB transfer starting in the current cycle (entered just after an
  // edge). c is the edge count at T2, i.e. through the end of T1.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output logic rdy1, output logic rdy2, output int unsigned c);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = wd; bus.pwstrb = st;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    rdy1 = bus.pready;
    @(posedge clk); #1;
    rdy2 = bus.pready; rd = bus.prdata; err = bus.pslverr; c = cyc;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic err, r1, r2; int unsigned c;
    logic [31:0] exp_rd [5];
    logic [15:0] addrs [5];
    addrs  = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
    exp_rd = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    repeat (3) @(posedge clk); #1;
    checks++;
    if (bus.pready !== 1'b0 || bus.prdata !== 32'h0 || bus.pslverr !== 1'b0 ||
        msip !== 1'b0 || mtip !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got pready=%b prdata=%h pslverr=%b msip=%b mtip=%b want all 0",
               bus.pready, bus.prdata, bus.pslverr, msip, mtip);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, addrs[i], 32'h0, 4'h0, rd, err, r1, r2, c);
      if (i == 3) exp_rd[i] = c / 4;
      checks++;
      if (rd !== exp_rd[i] || err !== 1'b0 || r1 !== 1'b0 || r2 !== 1'b1) begin
        failures++;
        $display("FAIL reset_read[%0d] got rd=%h err=%b rdy_t1=%b rdy_t2=%b want rd=%h err=0 rdy 0/1",
                 i, rd, err, r1, r2, exp_rd[i]);
      end
    end
  endtask

  task automatic test_prescaler;
    logic [31:0] rd; logic err, r1, r2; int unsigned c;
    repeat (40) @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, err, r1, r2, c);
      checks++;
      if (rd !== 32'(c / 4)) begin
        failures++;
        $display("FAIL prescaler_read[%0d] got %0d want %0d (edges %0d)", k, rd, c / 4, c);
      end
      repeat (k + 1) @(posedge clk); #1;
    end
  endtask

  task automatic test_msip;
    logic [31:0] rd; logic err, r1, r2; int unsigned c;
    xfer(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0001, rd, err, r1, r2, c);
    checks++;
    if (msip !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL msip_set got msip=%b err=%b want 1/0", msip, err);
    end
    xfer(1'b0, 16'h0000, 32'h0, 4'h0, rd, err, r1, r2, c);
    checks++;
    if (rd !== 32'h1) begin
      failures++;
      $display("FAIL msip_readback got %h want 00000001", rd);
    end
    xfer(1'b1, 16'h0000, 32'h0, 4'b1110, rd, err, r1, r2, c);
    checks++;
    if (msip !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL msip_strb_hold got msip=%b err=%b want 1/0", msip, err);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic err, r1, r2; int unsigned c;
    xfer(1'b0, 16'h0008, 32'h0, 4'h0, rd, err, r1, r2, c);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || r2 !== 1'b1) begin
      failures++;
      $display("FAIL err_unmapped_read got err=%b rd=%h rdy=%b want 1/0/1", err, rd, r2);
    end
    xfer(1'b1, 16'h4002, 32'h0, 4'hF, rd, err, r1, r2, c);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL err_misaligned_write got err=%b rd=%h want 1/0", err, rd);
    end
    xfer(1'b1, 16'h0001, 32'h0, 4'hF, rd, err, r1, r2, c);
    checks++;
    if (err !== 1'b1 || msip !== 1'b1) begin
      failures++;
      $display("FAIL err_msip_misaligned got err=%b msip=%b want 1/1", err, msip);
    end
    xfer(1'b0, 16'h4000, 32'h0, 4'h0, rd, err, r1, r2, c);
    checks++;
    if (rd !== 32'hFFFF_FFFF || err !== 1'b0) begin
      failures++;
      $display("FAIL err_no_side_effect got cmp_lo=%h err=%b want ffffffff/0", rd, err);
    end
    xfer(1'b1, 16'h0000, 32'h0, 4'b0001, rd, err, r1, r2, c);
    checks++;
    if (msip !== 1'b0) begin
      failures++;
      $display("FAIL msip_clear got %b want 0", msip);
    end
  endtask

  task automatic test_mtip;
    logic [31:0] rd, target; logic err, r1, r2, rose, exp_t; int unsigned c;
    xfer(1'b1, 16'h4004, 32'h0, 4'hF, rd, err, r1, r2, c);
    xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, err, r1, r2, c);
    target = c / 4 + 6;
    xfer(1'b1, 16'h4000, target, 4'hF, rd, err, r1, r2, c);
    @(posedge clk); #1;
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      // mtip now reflects the mtime held during the previous cycle
      exp_t = ((cyc - 1) / 4 >= target);
      checks++;
      if (mtip !== exp_t) begin
        failures++;
        $display("FAIL mtip_track cycle %0d got %b want %b (target %0d)", i, mtip, exp_t, target);
        break;
      end
      if (mtip) rose = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (rose !== 1'b1) begin
      failures++;
      $display("FAIL mtip_rise got %b want 1", rose);
    end
    xfer(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, rd, err, r1, r2, c);
    checks++;
    if (mtip !== 1'b1) begin
      failures++;
      $display("FAIL mtip_clear_t3 got %b want 1", mtip);
    end
    @(posedge clk); #1;
    checks++;
    if (mtip !== 1'b0) begin
      failures++;
      $display("FAIL mtip_clear_t4 got %b want 0", mtip);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic err, r1, r2; int unsigned c1, c2;
    xfer(1'b1, 16'h4004, 32'h1234_5678, 4'hF, rd, err, r1, r2, c1);
    xfer(1'b0, 16'h4004, 32'h0, 4'h0, rd, err, r1, r2, c2);
    checks++;
    if (rd !== 32'h1234_5678 || c2 - c1 != 3 || r2 !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back got rd=%h spacing=%0d rdy=%b want 12345678/3/1", rd, c2 - c1, r2);
    end
    xfer(1'b1, 16'h4004, 32'hAB00_0000, 4'b1000, rd, err, r1, r2, c1);
    xfer(1'b0, 16'h4004, 32'h0, 4'h0, rd, err, r1, r2, c2);
    checks++;
    if (rd !== 32'hAB34_5678) begin
      failures++;
      $display("FAIL cmp_byte_strobe got %h want ab345678", rd);
    end
  endtask

  task automatic test_mtime_write;
    logic [31:0] rd; logic err, r1, r2; int unsigned c, cw;
    logic [63:0] e;
`ifdef CLINT_MTIME_WRITE_EN
    xfer(1'b1, 16'hBFFC, 32'h0, 4'hF, rd, err, r1, r2, c);
    xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, err, r1, r2, c);
    cw = cyc;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL mtime_write_err got %b want 0", err);
    end
    repeat (10) @(posedge clk); #1;
    xfer(1'b0, 16'hBFFC, 32'h0, 4'h0, rd, err, r1, r2, c);
    e = 64'hFFFF_FFFF + 64'(c / 4 - cw / 4);
    checks++;
    if (rd !== e[63:32]) begin
      failures++;
      $display("FAIL mtime_carry_hi got %h want %h", rd, e[63:32]);
    end
    xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, err, r1, r2, c);
    e = 64'hFFFF_FFFF + 64'(c / 4 - cw / 4);
    checks++;
    if (rd !== e[31:0]) begin
      failures++;
      $display("FAIL mtime_carry_lo got %h want %h", rd, e[31:0]);
    end
`else
    xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, err, r1, r2, c);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL mtime_ro_lo got err=%b want 1", err);
    end
    xfer(1'b1, 16'hBFFC, 32'h0, 4'hF, rd, err, r1, r2, c);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL mtime_ro_hi got err=%b want 1", err);
    end
    xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, err, r1, r2, c);
    cw = c / 4;
    e = 64'(cw);
    checks++;
    if (rd !== e[31:0] || err !== 1'b0) begin
      failures++;
      $display("FAIL mtime_ro_count got %h err=%b want %h/0", rd, err, e[31:0]);
    end
`endif
  endtask

  task automatic test_reset_abort;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0000; bus.pwdata = 32'h1; bus.pwstrb = 4'b0001;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pready !== 1'b0) begin
      failures++;
      $display("FAIL abort_pready got %b want 0", bus.pready);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (msip !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_write got msip=%b want 0", msip);
    end
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 16'h0; bus.pwdata = 32'h0; bus.pwstrb = 4'h0;
    test_reset();
    test_prescaler();
    test_msip();
    test_errors();
    test_mtip();
    test_back_to_back();
    test_mtime_write();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
